// File: rtl/word_packer_pkg.sv
// rtl/word_packer_pkg.sv - shared defaults, header constant and FSM state type for word_packer
package word_packer_pkg;

  localparam int BUS_SIZE_DEF  = 16;
  localparam int WORD_SIZE_DEF = 4;
  localparam int WORD_NUM_DEF  = BUS_SIZE_DEF / WORD_SIZE_DEF;

  // Header word at the default word width; the top widens it to WORD_SIZE
  localparam logic [WORD_SIZE_DEF-1:0] HEADER = '1;

  // IDLE holds no payload words, FILL holds at least one
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

endpackage

// File: rtl/word_packer_bus_out_reg.sv
// rtl/word_packer_bus_out_reg.sv - output bus holding register with downstream stall handling
module bus_out_reg #(
  parameter int BUS_SIZE = 16,
  parameter int WORD_NUM = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [BUS_SIZE-1:0] load_data,
  input  logic [WORD_NUM-1:0] load_ctrl,
  input  logic                out_ready,
  output logic [BUS_SIZE-1:0] data_out,
  output logic [WORD_NUM-1:0] output_control,
  output logic                out_valid
);

  // Load a completed bus, otherwise hold it until downstream takes it.
  // A load only arrives when the slot is empty or being drained this cycle,
  // so loading over a handshake gives back-to-back buses with no bubble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_out       <= '0;
      output_control <= '0;
      out_valid      <= 1'b0;
    end else if (load) begin
      data_out       <= load_data;
      output_control <= load_ctrl;
      out_valid      <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid      <= 1'b0;
    end
  end

endmodule

// File: rtl/word_packer.sv
// rtl/word_packer.sv - packs header-prefixed words into a bus with early close and header-word rejection
module word_packer
  import word_packer_pkg::*;
#(
  parameter int BUS_SIZE  = BUS_SIZE_DEF,
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int WORD_NUM  = BUS_SIZE / WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] word_in,
  input  logic                 word_valid,
  input  logic                 word_last,
  output logic                 in_ready,
  input  logic                 out_ready,
  output logic [BUS_SIZE-1:0]  data_out,
  output logic [WORD_NUM-1:0]  output_control,
  output logic                 out_valid,
  output logic                 nxt_err,
  output logic                 err
);

  localparam int SLOTS = WORD_NUM - 1;
  localparam int CW    = $clog2(WORD_NUM);
  localparam logic [WORD_SIZE-1:0] HDR = {WORD_SIZE{1'b1}};

  state_t                           state;
  logic [CW-1:0]                    count;
  logic [SLOTS-1:0][WORD_SIZE-1:0]  slots;

  logic                             accept;
  logic                             is_hdr;
  logic                             store;
  logic                             complete;
  logic [CW:0]                      count_after;
  logic [SLOTS-1:0][WORD_SIZE-1:0]  slots_nxt;
  logic [SLOTS-1:0]                 mask_nxt;
  logic [BUS_SIZE-1:0]              load_data;
  logic [WORD_NUM-1:0]              load_ctrl;

  // Handshake, header rejection and the bus image as it would look after this word
  always_comb begin
    in_ready    = reset && (!out_valid || out_ready);
    accept      = word_valid && in_ready;
    is_hdr      = (word_in == HDR);
    nxt_err     = accept && is_hdr;
    store       = accept && !is_hdr;
    count_after = {1'b0, count} + {{CW{1'b0}}, store};
    slots_nxt   = slots;
    mask_nxt    = '0;
    for (int i = 0; i < SLOTS; i++) begin
      // slot SLOTS-1 is filled first, slot 0 last
      if (store && ((SLOTS - 1 - i) == int'(count))) begin
        slots_nxt[i] = word_in;
      end
      mask_nxt[i] = ((SLOTS - 1 - i) < int'(count_after));
    end
    // A dropped header word may still close a partial bus, never an empty one
    complete  = accept &&
                ((count_after == (CW+1)'(SLOTS)) ||
                 (word_last && ((state == ST_FILL) || store)));
    load_data = {HDR, slots_nxt};
    load_ctrl = {1'b1, mask_nxt};
  end

  // Fill FSM: store payload words, clear everything once a bus is handed off
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      count <= '0;
      slots <= '0;
    end else if (complete) begin
      state <= ST_IDLE;
      count <= '0;
      slots <= '0;
    end else if (store) begin
      state <= ST_FILL;
      count <= count_after[CW-1:0];
      slots <= slots_nxt;
    end
  end

  // Registered copy of the header-word error, a one-cycle pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      err <= 1'b0;
    end else begin
      err <= nxt_err;
    end
  end

  bus_out_reg #(
    .BUS_SIZE (BUS_SIZE),
    .WORD_NUM (WORD_NUM)
  ) u_bus_out_reg (
    .clk            (clk),
    .reset          (reset),
    .load           (complete),
    .load_data      (load_data),
    .load_ctrl      (load_ctrl),
    .out_ready      (out_ready),
    .data_out       (data_out),
    .output_control (output_control),
    .out_valid      (out_valid)
  );

endmodule
